// File: rtl/inte_n.sv
// inte_n: inverse differencing (integration) stage for the ARIMA forecast path.
// A d-th order differenced sample is integrated back to the original scale one
// difference order per cycle, using the per-order last values held in s[].
module inte_n #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int D_MAX = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [N-1:0]        d_order_in,
  input  logic                init_load,
  input  logic signed [N-1:0] init_vals [0:D_MAX-1],
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] data_out,
  output logic                initialised,
  output logic                ovf
);

  localparam int DW = $clog2(D_MAX + 1);
  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READY, S_ACC, S_OUT} state_e;

  state_e               state_q, state_d;
  logic signed [N-1:0]  s_q [D_MAX];
  logic signed [N-1:0]  s_d [D_MAX];
  logic [DW-1:0]        d_reg_q, d_reg_d;
  logic [DW-1:0]        k_q, k_d;
  logic signed [N-1:0]  acc_q, acc_d;
  logic signed [N-1:0]  dout_q, dout_d;
  logic                 init_q, init_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [DW-1:0]        d_clamp;
  logic signed [N:0]    sum_w;
  logic signed [N-1:0]  sat_t;
  logic                 sat_hit;

  assign accept  = in_valid && in_ready;
  assign d_clamp = (d_order_in > N'(D_MAX)) ? DW'(D_MAX) : d_order_in[DW-1:0];

  // Saturating add of the running value and the current order's last value.
  always_comb begin
    sum_w   = {acc_q[N-1], acc_q} + {s_q[k_q][N-1], s_q[k_q]};
    sat_hit = sum_w[N] ^ sum_w[N-1];
    sat_t   = sat_hit ? (sum_w[N] ? SAT_MIN : SAT_MAX) : sum_w[N-1:0];
  end

  // Next-state: init_load can restart from any state, clear overrides everything.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (init_load) begin
      state_d = S_READY;
    end else begin
      case (state_q)
        S_READY: if (accept) state_d = (d_reg_q == '0) ? S_OUT : S_ACC;
        S_ACC:   if (k_q == '0) state_d = S_OUT;
        S_OUT:   if (out_ready) state_d = S_READY;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath: seed on init_load, walk orders from d_reg-1 down to 0 in ACC.
  always_comb begin
    for (int i = 0; i < D_MAX; i++) s_d[i] = s_q[i];
    d_reg_d = d_reg_q;
    k_d     = k_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    init_d  = init_q;
    ovf_d   = ovf_q;
    if (clear) begin
      for (int i = 0; i < D_MAX; i++) s_d[i] = '0;
      d_reg_d = '0;
      k_d     = '0;
      acc_d   = '0;
      dout_d  = '0;
      init_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (init_load) begin
      for (int i = 0; i < D_MAX; i++) s_d[i] = init_vals[i];
      d_reg_d = d_clamp;
      ovf_d   = 1'b0;
      init_d  = 1'b1;
    end else begin
      case (state_q)
        S_READY: begin
          if (accept) begin
            acc_d = data_in;
            // Order 0 passes straight through; data_out only moves on entry to OUT.
            if (d_reg_q == '0) dout_d = data_in;
            else               k_d    = d_reg_q - 1'b1;
          end
        end
        S_ACC: begin
          s_d[k_q] = sat_t;
          acc_d    = sat_t;
          if (sat_hit) ovf_d = 1'b1;
          if (k_q == '0) dout_d = sat_t;
          else           k_d    = k_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs; in_ready is withheld in the cycle a reload or clear lands.
  always_comb begin
    in_ready    = (state_q == S_READY) && !init_load && !clear;
    out_valid   = (state_q == S_OUT);
    data_out    = dout_q;
    initialised = init_q;
    ovf         = ovf_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < D_MAX; i++) s_q[i] <= '0;
      d_reg_q <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      init_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < D_MAX; i++) s_q[i] <= s_d[i];
      d_reg_q <= d_reg_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      init_q  <= init_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
